// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline stall/flush controller.
package pipe_pkg;

    typedef enum logic {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

    localparam int unsigned DEF_MULT_CYCLES = 4;
    localparam int unsigned DEF_DIV_CYCLES  = 32;
    localparam int unsigned DEF_CNT_W       = 6;

endpackage

// File: rtl/muldiv_seq.sv
// Mult/div latency sequencer: tracks an in-flight operation and pulses done
// in its final cycle.
module muldiv_seq
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

    md_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Counter holds cycles remaining after the current one; it keeps
    // running through memory waits.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            MD_IDLE: begin
                if (start) begin
                    state_next = MD_BUSY;
                    cnt_next   = is_div ? DIV_LOAD : MULT_LOAD;
                end
            end
            MD_BUSY: begin
                if (cnt == '0) begin
                    state_next = MD_IDLE;
                end else begin
                    cnt_next = cnt - 1'b1;
                end
            end
            default: begin
                state_next = MD_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // Reset masks the outputs so an aborted operation never reports done.
    always_comb begin
        busy = (state == MD_BUSY) && !rst;
        done = busy && (cnt == '0);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer: merges hazards, branch flushes, memory wait
// and mult/div latency into per-stage enable and flush strobes.
module pipeline_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int unsigned DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic        id_muldiv,
    input  logic        id_is_div,
    input  logic        id_hilo_read,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_branch_taken,
    input  logic        mem_wait,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        id_ex_en,
    output logic        ex_mem_en,
    output logic        mem_wb_en,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        muldiv_start,
    output logic        muldiv_busy,
    output logic        muldiv_done,
    output logic [31:0] stall_count
);

    logic load_use;
    logic hilo_hazard;
    logic struct_hazard;
    logic any_hazard;

    always_comb begin
        load_use      = ex_mem_read && (ex_rd != REG_ZERO) &&
                        ((id_uses_rs && (id_rs == ex_rd)) ||
                         (id_uses_rt && (id_rt == ex_rd)));
        hilo_hazard   = id_hilo_read && muldiv_busy;
        struct_hazard = id_muldiv && muldiv_busy;
        any_hazard    = load_use || hilo_hazard || struct_hazard;
    end

    always_comb begin
        pc_en        = 1'b1;
        if_id_en     = 1'b1;
        id_ex_en     = 1'b1;
        ex_mem_en    = 1'b1;
        mem_wb_en    = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        muldiv_start = 1'b0;
        if (rst) begin
            // Hold the pipeline open and quiet while reset is applied.
        end else if (mem_wait) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
        end else if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (any_hazard) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
        end else begin
            muldiv_start = id_muldiv && !muldiv_busy;
        end
    end

    muldiv_seq #(
        .MULT_CYCLES (MULT_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES),
        .CNT_W       (CNT_W)
    ) u_muldiv_seq (
        .clk    (clk),
        .rst    (rst),
        .start  (muldiv_start),
        .is_div (id_is_div),
        .busy   (muldiv_busy),
        .done   (muldiv_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (!pc_en) begin
            stall_count <= stall_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random
// stimulus against a cycle-timestamp reference model.
module tb_pipeline_ctrl;

    localparam int MULT_N = 4;
    localparam int DIV_N  = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs, id_rt, ex_rd;
    logic        id_uses_rs, id_uses_rt, id_muldiv, id_is_div, id_hilo_read;
    logic        ex_mem_read, ex_branch_taken, mem_wait;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        if_id_flush, id_ex_flush;
    logic        muldiv_start, muldiv_busy, muldiv_done;
    logic [31:0] stall_count;

    int          n_checks = 0;
    int          n_fails  = 0;

    // Reference model: an operation is described by the cycle in which it
    // completes; busy covers every later cycle up to and including that one.
    int          cyc         = 0;
    bit          md_active   = 1'b0;
    int          md_done_cyc = 0;
    logic [31:0] exp_stall   = '0;

    logic [9:0]  last_ctrl;
    logic        last_done, last_pc_en, last_busy;

    pipeline_ctrl #(
        .MULT_CYCLES (MULT_N),
        .DIV_CYCLES  (DIV_N),
        .CNT_W       (6)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_uses_rs      (id_uses_rs),
        .id_uses_rt      (id_uses_rt),
        .id_muldiv       (id_muldiv),
        .id_is_div       (id_is_div),
        .id_hilo_read    (id_hilo_read),
        .ex_rd           (ex_rd),
        .ex_mem_read     (ex_mem_read),
        .ex_branch_taken (ex_branch_taken),
        .mem_wait        (mem_wait),
        .pc_en           (pc_en),
        .if_id_en        (if_id_en),
        .id_ex_en        (id_ex_en),
        .ex_mem_en       (ex_mem_en),
        .mem_wb_en       (mem_wb_en),
        .if_id_flush     (if_id_flush),
        .id_ex_flush     (id_ex_flush),
        .muldiv_start    (muldiv_start),
        .muldiv_busy     (muldiv_busy),
        .muldiv_done     (muldiv_done),
        .stall_count     (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, act, exp);
        end
    endtask

    task automatic clear_inputs();
        rst             = 1'b0;
        id_rs           = '0;
        id_rt           = '0;
        ex_rd           = '0;
        id_uses_rs      = 1'b0;
        id_uses_rt      = 1'b0;
        id_muldiv       = 1'b0;
        id_is_div       = 1'b0;
        id_hilo_read    = 1'b0;
        ex_mem_read     = 1'b0;
        ex_branch_taken = 1'b0;
        mem_wait        = 1'b0;
    endtask

    // Evaluate one cycle: compare DUT outputs with the model, then advance
    // the model across the coming clock edge.
    task automatic step();
        logic lu, b, hz, start, done;
        logic pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex;
        logic [9:0] exp_v, act_v;
        #3;
        lu = ex_mem_read && (ex_rd != 5'd0) &&
             ((id_uses_rs && id_rs == ex_rd) || (id_uses_rt && id_rt == ex_rd));
        b  = !rst && md_active;
        hz = lu || (id_hilo_read && b) || (id_muldiv && b);
        {pc, ifid, idex, exmem, memwb} = 5'b11111;
        {fl_ifid, fl_idex} = 2'b00;
        start = 1'b0;
        if (rst) begin
            {pc, ifid, idex, exmem, memwb} = 5'b11111;
        end else if (mem_wait) begin
            {pc, ifid, idex, exmem, memwb} = 5'b00000;
        end else if (ex_branch_taken) begin
            {fl_ifid, fl_idex} = 2'b11;
        end else if (hz) begin
            pc = 1'b0; ifid = 1'b0; fl_idex = 1'b1;
        end else begin
            start = id_muldiv && !b;
        end
        done  = b && (cyc == md_done_cyc);
        exp_v = {pc, ifid, idex, exmem, memwb, fl_ifid, fl_idex, start, b, done};
        act_v = {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                 if_id_flush, id_ex_flush, muldiv_start, muldiv_busy, muldiv_done};
        check("ctrl", {22'd0, act_v}, {22'd0, exp_v});
        check("stall_count", stall_count, exp_stall);
        last_ctrl  = act_v;
        last_done  = muldiv_done;
        last_pc_en = pc_en;
        last_busy  = muldiv_busy;
        if (rst) begin
            md_active = 1'b0;
            exp_stall = '0;
        end else begin
            if (!pc) exp_stall = exp_stall + 32'd1;
            if (done) md_active = 1'b0;
            if (start) begin
                md_active   = 1'b1;
                md_done_cyc = cyc + (id_is_div ? DIV_N : MULT_N);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int done_off, adv_off, stalled;

        clear_inputs();
        rst = 1'b1;
        @(posedge clk);
        #1;
        step();
        check("reset_ctrl", {22'd0, last_ctrl}, {22'd0, 10'b1111100000});
        rst = 1'b0;
        step();
        check("reset_stall", stall_count, 32'd0);

        // Load-use on rs: exactly one stall cycle.
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
        step();
        check("lu_ctrl", {22'd0, last_ctrl}, {22'd0, 10'b0011101000});
        clear_inputs();
        step();
        check("lu_stall_count", stall_count, 32'd1);
        check("lu_release", {31'd0, last_pc_en}, 32'd1);

        // Load to r0 never stalls; unused rt never stalls.
        ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
        step();
        check("lu_r0", {31'd0, last_pc_en}, 32'd1);
        ex_rd = 5'd8; id_rs = 5'd3; id_rt = 5'd8; id_uses_rt = 1'b0;
        step();
        check("lu_rt_unused", {31'd0, last_pc_en}, 32'd1);

        // Branch wins over a simultaneous load-use hazard.
        id_rs = 5'd8; id_uses_rs = 1'b1; ex_branch_taken = 1'b1;
        step();
        check("br_over_hazard", {22'd0, last_ctrl}, {22'd0, 10'b1111111000});
        clear_inputs();

        // Mult followed by mflo: done at +4, mflo advances at +5.
        id_muldiv = 1'b1;
        step();
        clear_inputs();
        id_hilo_read = 1'b1;
        done_off = -1; adv_off = -1; stalled = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (last_done) done_off = k;
            if (last_pc_en) begin adv_off = k; break; end
            stalled++;
        end
        check("mult_done_off", done_off, MULT_N);
        check("mflo_adv_off", adv_off, MULT_N + 1);
        check("mflo_stalls", stalled, MULT_N);
        clear_inputs();

        // Div with a 5-cycle mem_wait in the middle still completes at +32.
        id_muldiv = 1'b1; id_is_div = 1'b1;
        step();
        clear_inputs();
        done_off = -1;
        for (int k = 1; k <= 40; k++) begin
            mem_wait = (k >= 5 && k < 10);
            step();
            if (last_done) begin done_off = k; break; end
        end
        check("div_done_off", done_off, DIV_N);
        clear_inputs();

        // Reset while the div counter sits at 10.
        id_muldiv = 1'b1; id_is_div = 1'b1;
        step();
        clear_inputs();
        for (int k = 1; k <= 21; k++) step();
        check("pre_reset_busy", {31'd0, last_busy}, 32'd1);
        rst = 1'b1;
        step();
        check("reset_no_done", {31'd0, last_done}, 32'd0);
        rst = 1'b0;
        step();
        check("post_reset_busy", {31'd0, last_busy}, 32'd0);
        check("post_reset_stall", stall_count, 32'd0);
        id_muldiv = 1'b1;
        step();
        clear_inputs();
        done_off = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (last_done) begin done_off = k; break; end
        end
        check("restart_done_off", done_off, MULT_N);

        // Random traffic; small register range to provoke matches.
        for (int i = 0; i < 3000; i++) begin
            rst             = ($urandom_range(99) < 2);
            id_rs           = 5'($urandom_range(3));
            id_rt           = 5'($urandom_range(3));
            ex_rd           = 5'($urandom_range(3));
            id_uses_rs      = ($urandom_range(99) < 60);
            id_uses_rt      = ($urandom_range(99) < 40);
            id_muldiv       = ($urandom_range(99) < 15);
            id_is_div       = ($urandom_range(99) < 25);
            id_hilo_read    = ($urandom_range(99) < 20);
            ex_mem_read     = ($urandom_range(99) < 30);
            ex_branch_taken = ($urandom_range(99) < 12);
            mem_wait        = ($urandom_range(99) < 12);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage MIPS pipeline. It merges load-use hazard detection, branch-taken flushes, data-memory wait and a multi-cycle multiply/divide unit into one prioritised set of per-stage enable and flush strobes. It also owns the mult/div latency state machine and a stall-cycle performance counter. It sits beside the ID stage and drives every pipeline register's enable and flush inputs.

## Interface
- MULT_CYCLES, 4, mult/multu latency in cycles (≥1)
- DIV_CYCLES, 32, div/divu latency in cycles (≥1)
- CNT_W, 6, latency counter width; must hold max(MULT_CYCLES, DIV_CYCLES)
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rs, id_uses_rt  in  1 each  ID instruction actually reads rs/rt
- id_muldiv  in  1  ID holds mult/multu/div/divu
- id_is_div  in  1  qualifies id_muldiv; 1 = divide latency
- id_hilo_read  in  1  ID holds mfhi/mflo
- ex_rd  in  5  destination register of the instruction in EX
- ex_mem_read  in  1  EX instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX
- mem_wait  in  1  data memory not ready; freeze pipeline
- pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage register enables
- if_id_flush, id_ex_flush  out  1 each  load a bubble (NOP) on the next edge
- muldiv_start  out  1  one-cycle launch pulse to the mult/div datapath
- muldiv_busy  out  1  registered; mult/div in flight
- muldiv_done  out  1  one-cycle pulse; HI/LO written at the end of this cycle
- stall_count  out  32  cycles in which pc_en was 0; wraps modulo 2^32

## Operation
- Load-use hazard: ex_mem_read && ex_rd≠0 && ((id_uses_rs && id_rs==ex_rd) || (id_uses_rt && id_rt==ex_rd)).
- HI/LO hazard: id_hilo_read && muldiv_busy.
- Structural hazard: id_muldiv && muldiv_busy.
- Priority, highest first:
  1. **mem_wait:** all enables 0, no flushes.
  2. **ex_branch_taken:** all enables 1, if_id_flush=1, id_ex_flush=1.
  3. **Any hazard:** pc_en=0, if_id_en=0, id_ex_flush=1; the remaining enables stay 1.
  4. **Otherwise:** all enables 1, no flushes.
- muldiv_start = id_muldiv && !muldiv_busy && none of items 1–3 active.
- Mult/div FSM, with states IDLE and BUSY:
  - IDLE → BUSY on muldiv_start. The counter loads (id_is_div ? DIV_CYCLES : MULT_CYCLES) − 1.
  - In BUSY the counter decrements every cycle, including during mem_wait.
  - When count==0 in BUSY, muldiv_done=1 and the next state is IDLE.
  - muldiv_busy = (state==BUSY).
- stall_count increments in every cycle with pc_en==0 and rst==0.
- Reset:
  - State is IDLE, counter is 0, stall_count is 0.
  - muldiv_busy=0, muldiv_done=0, muldiv_start=0.
  - Enables are 1 and flushes are 0 while rst is high.
  - A reset during BUSY aborts the operation with no done pulse.

## Timing
- All enable/flush/start outputs are combinational from the current inputs and registered state, with zero-cycle latency.
- A start in cycle T gives busy high for T+1..T+N and muldiv_done at T+N, where N is the selected latency.
- mfhi in ID at any cycle in T+1..T+N stalls. It advances at T+N+1.
- If a branch and a hazard occur in the same cycle, the flush wins, so the wrong-path ID instruction is dropped without stalling.
- If mem_wait and a branch occur in the same cycle, the pipeline freezes. The branch is re-presented on the next cycle because EX is held.
- A mult/div held in ID by mem_wait does not start until mem_wait drops.

## Structure
- Shared package pipe_pkg holds:
  - FSM state typedef (MD_IDLE, MD_BUSY)
  - register-zero constant REG_ZERO = 5'd0
  - default latency constants
- Sub-module muldiv_seq holds the FSM, the latency counter and the busy/done outputs. The top level contains the hazard logic, the priority mux and stall_count.

## Test plan
- ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 → pc_en=0, if_id_en=0, id_ex_flush=1 for exactly one cycle; stall_count=1.
- Same as above with ex_rd=0 → no stall; also id_uses_rt=0 with id_rt=8 → no stall.
- ex_branch_taken=1 together with a load-use hazard → if_id_flush=1, id_ex_flush=1, pc_en=1, no stall.
- mult issued at T=10 (MULT_CYCLES=4), then mflo in ID at T=11 → busy 11..14, done at 14, mflo stalled 11..14 and advancing at 15.
- div issued, mem_wait held for 5 cycles mid-operation → done still at T+32; all enables 0 only while mem_wait is high.
- rst asserted at BUSY count=10 → next cycle busy=0, no done pulse, stall_count=0; a new mult starts cleanly.
